// File: rtl/fpio_fifo_pkg.sv
// Shared types and helpers for the fpio FIFO family.
//   fifo_mode_e  : output-stage behaviour (registered read or first-word-fall-through)
//   fifo_err_t   : sticky error flags carried as one register
//   clog2_depth  : address width needed to index a given number of words
package fpio_fifo_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  function automatic int unsigned clog2_depth(input int unsigned depth);
    int unsigned bits;
    bits = 0;
    while ((32'd1 << bits) < depth) begin
      bits++;
    end
    return bits;
  endfunction

endpackage

// File: rtl/fpio_fifo_ram.sv
// Storage array for the fpio FIFO: one write port, one synchronous read port.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (clears the read-data register only)
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read strobe
//   rd_addr_i  : read address
//   rd_data_o  : registered read data, held while rd_en_i is low
module fpio_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_BITS-1:0]  wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_BITS-1:0]  rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned WORDS = 32'd1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fpio_fifo_fwft.sv
// Single-clock FIFO with selectable first-word-fall-through or registered-read output.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : synchronous clear of contents (error flags kept)
//   err_clr         : clear sticky overflow/underflow
//   in_data_en/in_data     : push strobe and data
//   out_data_en            : pop strobe
//   out_data/out_valid     : head word (FWFT) or read data pulse (STD)
//   count/in_avail         : words held (output stage included) and free space
//   almost_full/almost_empty, overflow/underflow : level and sticky error flags
module fpio_fifo_fwft
  import fpio_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_BITS  = 4,
  parameter int unsigned AF_LVL     = 12,
  parameter int unsigned AE_LVL     = 2,
  parameter int unsigned FWFT       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  err_clr,
  input  logic                  in_data_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_data_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [FIFO_BITS:0]    count,
  output logic [FIFO_BITS:0]    in_avail,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH     = 32'd1 << FIFO_BITS;
  localparam int unsigned CNT_W     = FIFO_BITS + 1;
  localparam int unsigned ADDR_BITS = clog2_depth(DEPTH);
  localparam fifo_mode_e  MODE      = (FWFT != 0) ? FIFO_MODE_FWFT : FIFO_MODE_STD;

  localparam logic [FIFO_BITS:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [FIFO_BITS:0] AF_C    = CNT_W'(AF_LVL);
  localparam logic [FIFO_BITS:0] AE_C    = CNT_W'(AE_LVL);

  if (FIFO_BITS < 1) begin : g_chk_bits
    $error("fpio_fifo_fwft: FIFO_BITS must be at least 1");
  end
  if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_chk_af
    $error("fpio_fifo_fwft: AF_LVL out of range 1..DEPTH");
  end
  if (AE_LVL > DEPTH - 1) begin : g_chk_ae
    $error("fpio_fifo_fwft: AE_LVL out of range 0..DEPTH-1");
  end

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_BITS:0]   count_q, count_d;
  logic                 out_valid_q, out_valid_d;
  fifo_err_t            err_q, err_d;

  logic                 full;
  logic                 empty;
  logic [FIFO_BITS:0]   ram_cnt;
  logic                 push_ok;
  logic                 push_drop;
  logic                 pop_ok;
  logic                 pop_bad;
  logic                 rd_en;

  always_comb begin
    full      = (count_q == DEPTH_C);
    empty     = (count_q == '0);
    // Words still in the array, i.e. not yet moved into the output register.
    ram_cnt   = count_q - CNT_W'(out_valid_q);
    push_ok   = in_data_en && !full && !flush;
    push_drop = in_data_en && full && !flush;

    if (MODE == FIFO_MODE_FWFT) begin
      pop_ok      = out_data_en && out_valid_q && !flush;
      // Refill the output register when it is empty or being consumed; words
      // counted in ram_cnt were written in an earlier cycle, so no collision.
      rd_en       = (ram_cnt != '0) && (!out_valid_q || pop_ok) && !flush;
      out_valid_d = rd_en || (out_valid_q && !pop_ok);
    end else begin
      pop_ok      = out_data_en && !empty && !flush;
      rd_en       = pop_ok;
      out_valid_d = pop_ok;
    end
    pop_bad = out_data_en && !pop_ok && !flush;

    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end

    wr_ptr_d = wr_ptr_q + ADDR_BITS'(push_ok);
    rd_ptr_d = rd_ptr_q + ADDR_BITS'(rd_en);

    err_d = err_clr ? '0 : err_q;
    if (push_drop) begin
      err_d.overflow = 1'b1;
    end
    if (pop_bad) begin
      err_d.underflow = 1'b1;
    end

    if (flush) begin
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  fpio_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_ram (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (push_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (out_data)
  );

  assign out_valid    = out_valid_q;
  assign count        = count_q;
  assign in_avail     = DEPTH_C - count_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_fpio_fifo_fwft.sv
// Bench for fpio_fifo_fwft: one FWFT instance and one registered-read instance
// share the stimulus; each is compared every cycle against a queue-style model.
module tb_fpio_fifo_fwft;

  localparam int DW    = 32;
  localparam int FB    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, err_clr, in_en, out_en;
  logic [DW-1:0] din;

  // index 0: registered-read instance, index 1: FWFT instance
  logic [DW-1:0] od    [2];
  logic          ov    [2];
  logic [FB:0]   cnt   [2];
  logic [FB:0]   avail [2];
  logic          af    [2];
  logic          ae    [2];
  logic          of_   [2];
  logic          uf    [2];

  fpio_fifo_fwft #(
    .DATA_WIDTH (DW), .FIFO_BITS (FB), .AF_LVL (AF), .AE_LVL (AE), .FWFT (0)
  ) u_std (
    .clk (clk), .rst (rst), .flush (flush), .err_clr (err_clr),
    .in_data_en (in_en), .in_data (din), .out_data_en (out_en),
    .out_data (od[0]), .out_valid (ov[0]), .count (cnt[0]), .in_avail (avail[0]),
    .almost_full (af[0]), .almost_empty (ae[0]), .overflow (of_[0]), .underflow (uf[0])
  );

  fpio_fifo_fwft #(
    .DATA_WIDTH (DW), .FIFO_BITS (FB), .AF_LVL (AF), .AE_LVL (AE), .FWFT (1)
  ) u_fwft (
    .clk (clk), .rst (rst), .flush (flush), .err_clr (err_clr),
    .in_data_en (in_en), .in_data (din), .out_data_en (out_en),
    .out_data (od[1]), .out_valid (ov[1]), .count (cnt[1]), .in_avail (avail[1]),
    .almost_full (af[1]), .almost_empty (ae[1]), .overflow (of_[1]), .underflow (uf[1])
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: circular list of stored words plus the visible output.
  logic [DW-1:0] mbuf  [2][DEPTH];
  int            msize [2];
  int            mhead [2];
  logic          mov   [2];
  logic [DW-1:0] mod_  [2];
  logic          mof   [2];
  logic          muf   [2];

  task automatic model_step(input int m);
    bit            push_ok, drop, pop_ok, rd;
    logic [DW-1:0] head_w;
    if (rst) begin
      msize[m] = 0; mhead[m] = 0; mov[m] = 1'b0; mod_[m] = '0;
      mof[m] = 1'b0; muf[m] = 1'b0;
      return;
    end
    if (err_clr) begin
      mof[m] = 1'b0; muf[m] = 1'b0;
    end
    if (flush) begin
      msize[m] = 0; mhead[m] = 0; mov[m] = 1'b0;
      return;
    end
    push_ok = in_en && (msize[m] != DEPTH);
    drop    = in_en && (msize[m] == DEPTH);
    if (m == 1) pop_ok = out_en && mov[m];
    else        pop_ok = out_en && (msize[m] != 0);
    // FWFT: a word not yet shown is moved up when the output is free or consumed.
    rd = (m == 1) && ((msize[m] - int'(mov[m])) != 0) && (!mov[m] || pop_ok);
    head_w = mbuf[m][mhead[m]];
    if (pop_ok) begin
      mhead[m] = (mhead[m] + 1) % DEPTH;
      msize[m]--;
    end
    if (push_ok) begin
      mbuf[m][(mhead[m] + msize[m]) % DEPTH] = din;
      msize[m]++;
    end
    if (m == 1) begin
      mov[m] = rd || (mov[m] && !pop_ok);
      if (rd) mod_[m] = mbuf[m][mhead[m]];
    end else begin
      mov[m] = pop_ok;
      if (pop_ok) mod_[m] = head_w;
    end
    if (drop) mof[m] = 1'b1;
    if (out_en && !pop_ok) muf[m] = 1'b1;
  endtask

  task automatic check_all();
    string pfx;
    for (int m = 0; m < 2; m++) begin
      pfx = (m == 1) ? "fwft" : "std";
      chk($sformatf("%s.count", pfx),        64'(cnt[m]),   64'(msize[m]));
      chk($sformatf("%s.in_avail", pfx),     64'(avail[m]), 64'(DEPTH - msize[m]));
      chk($sformatf("%s.out_valid", pfx),    64'(ov[m]),    64'(mov[m]));
      chk($sformatf("%s.out_data", pfx),     64'(od[m]),    64'(mod_[m]));
      chk($sformatf("%s.almost_full", pfx),  64'(af[m]),    64'(msize[m] >= AF));
      chk($sformatf("%s.almost_empty", pfx), 64'(ae[m]),    64'(msize[m] <= AE));
      chk($sformatf("%s.overflow", pfx),     64'(of_[m]),   64'(mof[m]));
      chk($sformatf("%s.underflow", pfx),    64'(uf[m]),    64'(muf[m]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit p, input logic [DW-1:0] d, input bit q,
                       input bit fl = 1'b0, input bit ec = 1'b0);
    in_en = p; din = d; out_en = q; flush = fl; err_clr = ec;
    cycle();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; err_clr = 1'b0; in_en = 1'b0; out_en = 1'b0; din = '0;
    cycle();
    cycle();
    chk("reset.almost_empty", 64'(ae[1]), 64'd1);
    chk("reset.in_avail", 64'(avail[1]), 64'd4);
    rst = 1'b0;

    // First-word latency in FWFT mode.
    drive(1'b1, 32'hA, 1'b0);
    chk("t1.count_c1", 64'(cnt[1]), 64'd1);
    drive(1'b0, '0, 1'b0);
    chk("t1.valid_c2", 64'(ov[1]), 64'd1);
    chk("t1.data_c2", 64'(od[1]), 64'hA);

    // Fill, overflow, drain back-to-back.
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(i), 1'b0);
    drive(1'b1, 32'h55, 1'b0);
    chk("t2.overflow", 64'(of_[1]), 64'd1);
    chk("t2.count_full", 64'(cnt[1]), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2.drain_data", 64'(od[1]), 64'(i));
      drive(1'b0, '0, 1'b1);
    end
    chk("t2.drained_valid", 64'(ov[1]), 64'd0);

    // Underflow and error clear.
    drive(1'b0, '0, 1'b1);
    chk("t3.underflow", 64'(uf[1]), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t3.err_clr", 64'(uf[1]), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("t3.err_clr_vs_new", 64'(uf[1]), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Registered-read pulse and simultaneous push/pop.
    drive(1'b1, 32'h11, 1'b0);
    drive(1'b1, 32'h22, 1'b0);
    drive(1'b0, '0, 1'b1);
    chk("t4.std_pulse", 64'(ov[0]), 64'd1);
    chk("t4.std_data", 64'(od[0]), 64'h11);
    drive(1'b0, '0, 1'b0);
    chk("t4.std_pulse_end", 64'(ov[0]), 64'd0);
    drive(1'b1, 32'h33, 1'b0);
    drive(1'b1, 32'h44, 1'b1);
    chk("t4.std_count_same", 64'(cnt[0]), 64'd2);

    // Level flags while filling from empty.
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(32'h100 + i), 1'b0);
      if (i == 1) chk("t5.ae_drop_at2", 64'(ae[1]), 64'd0);
      if (i == 2) chk("t5.af_rise_at3", 64'(af[1]), 64'd1);
    end

    // Flush beats a simultaneous push; then wrap pointers with data checks.
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(32'h200 + i), 1'b0);
    drive(1'b1, 32'h99, 1'b0, 1'b1);
    chk("t6.flush_count", 64'(cnt[1]), 64'd0);
    chk("t6.flush_valid", 64'(ov[1]), 64'd0);
    chk("t6.flush_no_ovf", 64'(of_[1]), 64'd0);
    drive(1'b1, 32'h300, 1'b0);
    drive(1'b0, '0, 1'b0);
    for (int k = 1; k <= 2 * DEPTH + 1; k++) drive(1'b1, DW'(32'h300 + k), 1'b1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) < 55,
            $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0);
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
